// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard interface: ID-stage instruction fields in, stall and
// scoreboard status out.
interface hazard_scoreboard_if #(
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int PCNT_W = 32
);
    logic              valid_i;
    logic [AW-1:0]     rs_i;
    logic [AW-1:0]     rt_i;
    logic              rs_use_i;
    logic              rt_use_i;
    logic              branch_i;
    logic [AW-1:0]     rd_i;
    logic              reg_write_i;
    logic              mem_read_i;
    logic              mul_i;
    logic              flush_i;
    logic              freeze_i;
    logic              stall_o;
    logic [NREG-1:0]   pending_o;
    logic [PCNT_W-1:0] stall_cnt_o;

    modport master (
        output valid_i, rs_i, rt_i, rs_use_i, rt_use_i, branch_i,
               rd_i, reg_write_i, mem_read_i, mul_i, flush_i, freeze_i,
        input  stall_o, pending_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, rs_i, rt_i, rs_use_i, rt_use_i, branch_i,
               rd_i, reg_write_i, mem_read_i, mul_i, flush_i, freeze_i,
        output stall_o, pending_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use / branch hazard unit built on a per-register countdown scoreboard.
// cnt_q[r] is the number of cycles until register r becomes forwardable;
// register 0 is never loaded and therefore stays 0.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 3,
    parameter int PCNT_W   = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    hazard_scoreboard_if.slave bus
);
    localparam int MAX_LAT = (ALU_LAT > LOAD_LAT)
                           ? ((ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT)
                           : ((LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT);
    localparam int CW = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [NREG-1:0][CW-1:0] cnt_q;
    logic [NREG-1:0][CW-1:0] cnt_nxt;
    logic [CW-1:0]           need;
    logic [CW-1:0]           lat;
    logic                    rs_haz;
    logic                    rt_haz;
    logic                    stall;
    logic                    issue;
    logic                    wr_en;
    logic                    pcnt_inc;
    logic [PCNT_W-1:0]       stall_cnt_q;

    // Countdown step that stops at zero.
    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
        return (c == '0) ? c : (c - CW'(1));
    endfunction

    // A newer write never shortens an older, longer-latency result (WAW).
    function automatic logic [CW-1:0] max_cnt(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Performance counter increment that sticks at all-ones.
    function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] c);
        return (&c) ? c : (c + PCNT_W'(1));
    endfunction

    // Hazard detection against the current scoreboard; branches resolve in ID
    // so they need the value fully available, ALU consumers can take it
    // through EX-to-EX forwarding one cycle early.
    always_comb begin
        need     = bus.branch_i ? '0 : CW'(1);
        rs_haz   = bus.rs_use_i && (bus.rs_i != '0) && (cnt_q[bus.rs_i] > need);
        rt_haz   = bus.rt_use_i && (bus.rt_i != '0) && (cnt_q[bus.rt_i] > need);
        stall    = bus.valid_i && (rs_haz || rt_haz);
        issue    = bus.valid_i && !stall && !bus.flush_i && !bus.freeze_i;
        wr_en    = issue && bus.reg_write_i && (bus.rd_i != '0);
        pcnt_inc = stall && !bus.flush_i && !bus.freeze_i;
        if (bus.mem_read_i)
            lat = CW'(LOAD_LAT);
        else if (bus.mul_i)
            lat = CW'(MUL_LAT);
        else
            lat = CW'(ALU_LAT);
    end

    // Next scoreboard: every entry counts down, the issuing destination is
    // (re)loaded with its producer latency. A self-dependency sees the old
    // count because detection above reads cnt_q, not cnt_nxt.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = sat_dec(cnt_q[r]);
            if (wr_en && (bus.rd_i == AW'(r)))
                cnt_nxt[r] = max_cnt(lat, sat_dec(cnt_q[r]));
        end
    end

    // Scoreboard register; a freeze holds every entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (!bus.freeze_i)
            cnt_q <= cnt_nxt;
    end

    // Saturating count of cycles lost to hazards (flush/freeze excluded).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt_q <= '0;
        else if (pcnt_inc)
            stall_cnt_q <= sat_inc(stall_cnt_q);
    end

    // Per-register in-flight flags.
    always_comb begin
        for (int r = 0; r < NREG; r++)
            bus.pending_o[r] = (cnt_q[r] != '0);
    end

    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table plus
// hand-written reset and counter-saturation sequences.
module tb_hazard_scoreboard;
    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rs_use;
        logic        rt_use;
        logic        branch;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mul;
        logic        flush;
        logic        freeze;
        logic        exp_stall;
        logic [31:0] exp_pend;
        logic [31:0] exp_scnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [4:0] rs = '0, rt = '0, rd = '0;
    logic       rs_use = 1'b0, rt_use = 1'b0, branch = 1'b0;
    logic       rw = 1'b0, mr = 1'b0, mul = 1'b0, flush = 1'b0, freeze = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(32), .AW(5), .PCNT_W(32)) hif ();
    hazard_scoreboard_if #(.NREG(32), .AW(5), .PCNT_W(4))  hif_sat ();

    assign hif.valid_i     = valid;
    assign hif.rs_i        = rs;
    assign hif.rt_i        = rt;
    assign hif.rs_use_i    = rs_use;
    assign hif.rt_use_i    = rt_use;
    assign hif.branch_i    = branch;
    assign hif.rd_i        = rd;
    assign hif.reg_write_i = rw;
    assign hif.mem_read_i  = mr;
    assign hif.mul_i       = mul;
    assign hif.flush_i     = flush;
    assign hif.freeze_i    = freeze;

    assign hif_sat.valid_i     = valid;
    assign hif_sat.rs_i        = rs;
    assign hif_sat.rt_i        = rt;
    assign hif_sat.rs_use_i    = rs_use;
    assign hif_sat.rt_use_i    = rt_use;
    assign hif_sat.branch_i    = branch;
    assign hif_sat.rd_i        = rd;
    assign hif_sat.reg_write_i = rw;
    assign hif_sat.mem_read_i  = mr;
    assign hif_sat.mul_i       = mul;
    assign hif_sat.flush_i     = flush;
    assign hif_sat.freeze_i    = freeze;

    hazard_scoreboard #(.NREG(32), .AW(5), .ALU_LAT(1), .LOAD_LAT(2),
                        .MUL_LAT(3), .PCNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (hif)
    );

    hazard_scoreboard #(.NREG(32), .AW(5), .ALU_LAT(1), .LOAD_LAT(2),
                        .MUL_LAT(3), .PCNT_W(4)) dut_sat (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (hif_sat)
    );

    function automatic logic [31:0] B(input int r);
        return 32'h1 << r;
    endfunction

    function automatic vec_t mk(input logic v, input int s, input int t,
                                input logic su, input logic tu, input logic br,
                                input int d, input logic w, input logic m,
                                input logic mu, input logic fl, input logic fz,
                                input logic es, input logic [31:0] ep,
                                input int esc);
        vec_t x;
        x.valid = v;   x.rs = 5'(s);  x.rt = 5'(t);
        x.rs_use = su; x.rt_use = tu; x.branch = br;
        x.rd = 5'(d);  x.rw = w;      x.mr = m;  x.mul = mu;
        x.flush = fl;  x.freeze = fz;
        x.exp_stall = es; x.exp_pend = ep; x.exp_scnt = 32'(esc);
        return x;
    endfunction

    function automatic vec_t v_idle(input logic [31:0] ep, input int esc);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep, esc);
    endfunction
    function automatic vec_t v_lw(input int d, input logic fl, input logic fz,
                                  input logic es, input logic [31:0] ep, input int esc);
        return mk(1, 0, 0, 0, 0, 0, d, 1, 1, 0, fl, fz, es, ep, esc);
    endfunction
    function automatic vec_t v_mul(input int d, input logic es,
                                   input logic [31:0] ep, input int esc);
        return mk(1, 0, 0, 0, 0, 0, d, 1, 0, 1, 0, 0, es, ep, esc);
    endfunction
    function automatic vec_t v_add(input int d, input int s, input int t,
                                   input logic fl, input logic fz, input logic es,
                                   input logic [31:0] ep, input int esc);
        return mk(1, s, t, 1, 1, 0, d, 1, 0, 0, fl, fz, es, ep, esc);
    endfunction
    function automatic vec_t v_beq(input int s, input int t, input logic es,
                                   input logic [31:0] ep, input int esc);
        return mk(1, s, t, 1, 1, 1, 0, 0, 0, 0, 0, 0, es, ep, esc);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        valid = v.valid;   rs = v.rs;   rt = v.rt;
        rs_use = v.rs_use; rt_use = v.rt_use; branch = v.branch;
        rd = v.rd;         rw = v.rw;   mr = v.mr; mul = v.mul;
        flush = v.flush;   freeze = v.freeze;
    endtask

    // Drive at the falling edge, check stall_o combinationally, then check the
    // registered state just after the following rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        apply(v);
        #1;
        chk("stall_o", idx, 32'(hif.stall_o), 32'(v.exp_stall));
        @(posedge clk);
        #1;
        chk("pending_o", idx, hif.pending_o, v.exp_pend);
        chk("stall_cnt_o", idx, hif.stall_cnt_o, v.exp_scnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sat_exp;
        int stalls;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pending", 0, hif.pending_o, 32'h0);
        chk("reset_stall_cnt", 0, hif.stall_cnt_o, 32'h0);
        chk("reset_stall", 0, 32'(hif.stall_o), 32'h0);
        rst = 1'b0;

        // lw $5 ; add $6,$5,$7 -> one stall
        tbl.push_back(v_lw(5, 0, 0, 0, B(5), 0));
        tbl.push_back(v_add(6, 5, 7, 0, 0, 1, B(5), 1));
        tbl.push_back(v_add(6, 5, 7, 0, 0, 0, B(6), 1));
        tbl.push_back(v_idle(0, 1));
        // add $5 ; add $6,$5,$7 -> no stall
        tbl.push_back(v_add(5, 1, 2, 0, 0, 0, B(5), 1));
        tbl.push_back(v_add(6, 5, 7, 0, 0, 0, B(6), 1));
        tbl.push_back(v_idle(0, 1));
        // lw $8 ; beq $8,$9 -> two stalls
        tbl.push_back(v_lw(8, 0, 0, 0, B(8), 1));
        tbl.push_back(v_beq(8, 9, 1, B(8), 2));
        tbl.push_back(v_beq(8, 9, 1, 0, 3));
        tbl.push_back(v_beq(8, 9, 0, 0, 3));
        // mul $8 ; beq $8,$0 -> three stalls
        tbl.push_back(v_mul(8, 0, B(8), 3));
        tbl.push_back(v_beq(8, 0, 1, B(8), 4));
        tbl.push_back(v_beq(8, 0, 1, B(8), 5));
        tbl.push_back(v_beq(8, 0, 1, 0, 6));
        tbl.push_back(v_beq(8, 0, 0, 0, 6));
        // lw $0 ; add $1,$0,$0 -> no stall, $0 never pending
        tbl.push_back(v_lw(0, 0, 0, 0, 0, 6));
        tbl.push_back(v_add(1, 0, 0, 0, 0, 0, B(1), 6));
        tbl.push_back(v_idle(0, 6));
        // mul $4 ; add $4 ; reader of $4 -> cnt[4]=2 so reader stalls once
        tbl.push_back(v_mul(4, 0, B(4), 6));
        tbl.push_back(v_add(4, 1, 2, 0, 0, 0, B(4), 6));
        tbl.push_back(v_add(9, 4, 0, 0, 0, 1, B(4), 7));
        tbl.push_back(v_add(9, 4, 0, 0, 0, 0, B(9), 7));
        tbl.push_back(v_idle(0, 7));
        // flushed lw $3 never becomes pending
        tbl.push_back(v_lw(3, 1, 0, 0, 0, 7));
        tbl.push_back(v_add(6, 3, 0, 0, 0, 0, B(6), 7));
        tbl.push_back(v_idle(0, 7));
        // flushed hazarding consumer: stall_o shown, not counted
        tbl.push_back(v_lw(5, 0, 0, 0, B(5), 7));
        tbl.push_back(v_add(6, 5, 0, 1, 0, 1, B(5), 7));
        tbl.push_back(v_idle(0, 7));
        // lw $3 then 4 frozen cycles with a reader, then one real stall
        tbl.push_back(v_lw(3, 0, 0, 0, B(3), 7));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v_add(7, 3, 0, 0, 1, 1, B(3), 7));
        tbl.push_back(v_add(7, 3, 0, 0, 0, 1, B(3), 8));
        tbl.push_back(v_add(7, 3, 0, 0, 0, 0, B(7), 8));
        tbl.push_back(v_idle(0, 8));
        // frozen instruction does not issue
        tbl.push_back(v_lw(10, 0, 1, 0, 0, 8));
        tbl.push_back(v_idle(0, 8));
        // self-dependency lw $5,0($5) uses the old count
        tbl.push_back(v_lw(5, 0, 0, 0, B(5), 8));
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1, B(5), 9));
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, B(5), 9));
        tbl.push_back(v_idle(B(5), 9));
        tbl.push_back(v_idle(0, 9));

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Mid-stream asynchronous reset with cnt[5]=2
        run_vec(v_lw(5, 0, 0, 0, B(5), 9), 100);
        @(negedge clk);
        apply(v_idle(0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pending", 0, hif.pending_o, 32'h0);
        chk("async_rst_stall_cnt", 0, hif.stall_cnt_o, 32'h0);
        chk("async_rst_stall_cnt_sat", 0, 32'(hif_sat.stall_cnt_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(v_add(6, 5, 7, 0, 0, 0, B(6), 0), 101);
        run_vec(v_idle(0, 0), 102);

        // Saturation on the 4-bit counter: 7 x (mul $5 ; 3 stalling beq)
        sat_exp = 0;
        stalls  = 0;
        for (int it = 0; it < 7; it++) begin
            @(negedge clk);
            apply(v_mul(5, 0, 0, 0));
            #1;
            chk("sat_mul_stall", it, 32'(hif_sat.stall_o), 32'h0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                apply(v_beq(5, 0, 0, 0, 0));
                #1;
                chk("sat_beq_stall", it * 3 + k, 32'(hif_sat.stall_o), 32'h1);
                @(posedge clk);
                #1;
                stalls++;
                if (sat_exp < 15) sat_exp++;
                chk("sat_stall_cnt", it * 3 + k, 32'(hif_sat.stall_cnt_o), 32'(sat_exp));
            end
        end
        chk("sat_final", 0, 32'(hif_sat.stall_cnt_o), 32'd15);
        chk("wide_cnt_final", 0, hif.stall_cnt_o, 32'(stalls));

        @(negedge clk);
        apply(v_idle(0, 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
